wshb_stream_sink: RTL and testbench
===================================

Name: wshb_stream_sink

Overview:
- Wishbone B4 slave (registered-feedback, classic and incrementing-burst cycles) acting as the responder on the internal stream bus driven by hw_support.
- Replaces the tied-off responder (constant ack) with a real one: writes to the data port are pushed into a FIFO, and a valid/ready port drains the FIFO towards downstream logic.
- Stalls the initiator by withholding ack when the FIFO is full. Also exposes status and control words.

Parameters:
- DEPTH, 16, FIFO depth in 32-bit words; power of 2, range 2..1024.
- CNT_W, $clog2(DEPTH)+1, width of the fill counter (derived; not overridden).

Ports:
- sys_clk  in  1  system clock, 100 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- cyc  in  1  Wishbone cycle
- stb  in  1  Wishbone strobe
- we  in  1  write enable
- adr  in  32  byte address; only adr[3:2] decoded
- dat_ms  in  32  write data
- sel  in  4  byte selects
- cti  in  3  cycle type (000 classic, 010 incrementing, 111 end of burst)
- bte  in  2  burst type, ignored
- dat_sm  out  32  read data
- ack  out  1  normal termination
- err  out  1  error termination
- rty  out  1  tied 0
- out_data  out  32  FIFO head
- out_valid  out  1  FIFO not empty
- out_ready  in  1  downstream accepts head

Behaviour:
- Reset: async on sys_rst_n low. All state clears immediately:
  - ack=0, err=0, dat_sm=0
  - FIFO empty: out_valid=0, out_data=0, count=0
  - stall flag=0
- Address map (adr[3:2]):
  - 0 DATA: write pushes dat_ms; read returns 0.
  - 1 STATUS: read-only; writes are acked and ignored. Word layout:
    - [CNT_W-1:0] count
    - [16] empty
    - [17] full
    - [18] stall sticky
    - other bits 0
  - 2 CTRL: write bit0=1 flushes the FIFO; bit1=1 clears stall. Reads return 0.
  - 3: err.
- Beat acceptance in cycle N. A beat is "presented" when cyc & stb & (~ack_q | prev_incr).
  - prev_incr is registered: 1 when the beat acked in the previous cycle had cti==010, else 0.
  - Classic and end-of-burst beats therefore get one beat per ack pulse. Incrementing bursts get back-to-back acks.
- Termination of a presented beat: ack or err rises at N+1, single cycle per beat. ack and err are never both 1.
  - err when adr[3:2]==3, or when we=1 and sel!=4'hF. No side effects on err.
  - Write DATA needs space: count<DEPTH at cycle N. A simultaneous pop in N does not create space. Without space the beat is held: no ack, stall flag set, re-evaluated every cycle.
  - Other beats are accepted unconditionally.
- Write timing: the DATA push happens at the edge ending N, so count and out_valid reflect it in N+1 together with ack.
- Read timing: dat_sm is registered at the edge ending N and valid with ack at N+1. dat_sm holds its value otherwise. STATUS returns values sampled in N.
- Pop: on out_valid & out_ready, head advances at the edge.
  - out_data is the head word, valid whenever out_valid=1.
  - Push and pop in the same cycle leave count unchanged.
- Flush: CTRL bit0 takes effect at the edge ending the accepting cycle. count=0 and out_valid=0 in the next cycle. Flush wins over a simultaneous pop.
- cyc low: no beat presented. ack/err are 0 the next cycle. A held (stalled) write is abandoned with no push.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. full = (count==DEPTH). empty = (count==0).
- bte is ignored; cti values other than 010 are treated as classic.

Test Plan:
1. Reset mid-burst: assert sys_rst_n=0 during an incrementing write burst with 3 words pushed -> ack=0, count=0, out_valid=0 in the same cycle, with no clock needed.
2. Classic write, then STATUS read, DEPTH=16:
   - Write 0xDEADBEEF to adr 0x0 -> ack at N+1.
   - Read adr 0x4 -> dat_sm=0x00000001.
   - out_data=0xDEADBEEF and out_valid=1.
3. Incrementing burst of 4 beats (cti 010,010,010,111), out_ready=0 -> acks on 4 consecutive cycles, count=4.
4. Full stall, DEPTH=16, out_ready=0:
   - 17th write is held with no ack, and STATUS bit18=1.
   - Pulse out_ready for 1 cycle -> ack arrives 1 cycle after space appears, count=16.
5. Errors: write to adr 0xC -> err=1, ack=0; write to adr 0x0 with sel=4'h3 -> err=1 and count unchanged.
6. Flush vs pop: with count=5, write 0x1 to CTRL while out_ready=1 -> count=0 and out_valid=0 next cycle; the pop has no effect.

Source files
------------

// File: rtl/wshb_stream_sink.sv
// wshb_stream_sink
//   Wishbone B4 slave (registered feedback; classic and incrementing-burst
//   cycles) that terminates the internal stream bus. Writes to the DATA word
//   push into a FIFO, which a valid/ready port drains towards downstream logic.
//   When the FIFO is full, the slave withholds ack to stall the initiator.
//
// Address map (adr[3:2]):
//   0 DATA    write pushes dat_ms, read returns 0
//   1 STATUS  {13'b0, stall, full, empty, 0.., count}; writes acked and ignored
//   2 CTRL    write bit0 flushes the FIFO, bit1 clears the stall flag; reads 0
//   3         error termination
//
// Ports:
//   i_sys_clk, i_sys_rst_n         clock, asynchronous active-low reset
//   i_cyc, i_stb, i_we, i_adr,     Wishbone request (i_bte ignored,
//   i_dat_ms, i_sel, i_cti, i_bte  cti other than 010 treated as classic)
//   o_dat_sm, o_ack, o_err, o_rty  Wishbone response (o_rty tied 0)
//   o_out_data, o_out_valid,       FIFO head, drained on valid & ready
//   i_out_ready
module wshb_stream_sink #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst_n,
    input  logic        i_cyc,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_dat_ms,
    input  logic [3:0]  i_sel,
    input  logic [2:0]  i_cti,
    input  logic [1:0]  i_bte,
    output logic [31:0] o_dat_sm,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_rty,
    output logic [31:0] o_out_data,
    output logic        o_out_valid,
    input  logic        i_out_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ack;
    logic             r_err;
    logic             r_prev_incr;
    logic             r_stall;
    logic [31:0]      r_dat_sm;

    logic [1:0]  w_region;
    logic        w_presented;
    logic        w_err;
    logic        w_data_wr;
    logic        w_space;
    logic        w_hold;
    logic        w_ack;
    logic        w_push;
    logic        w_pop;
    logic        w_ctrl_wr;
    logic        w_flush;
    logic        w_incr;
    logic        w_empty;
    logic        w_full;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_region = i_adr[3:2];
    assign w_incr   = (i_cti == 3'b010);
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));

    // A beat still on the bus during its own ack cycle is the same beat; only an
    // incrementing burst may present the next beat while the previous ack is high.
    assign w_presented = i_cyc & i_stb & (~(r_ack | r_err) | r_prev_incr);

    assign w_err     = w_presented & ((w_region == 2'd3) | (i_we & (i_sel != 4'hF)));
    assign w_data_wr = w_presented & ~w_err & i_we & (w_region == 2'd0);
    // Space is judged on the registered count, so a pop in the same cycle
    // does not let a full FIFO accept a push.
    assign w_space   = (r_count < CNT_W'(DEPTH));
    assign w_hold    = w_data_wr & ~w_space;
    assign w_ack     = w_presented & ~w_err & ~w_hold;
    assign w_push    = w_data_wr & w_space;
    assign w_ctrl_wr = w_ack & i_we & (w_region == 2'd2);
    assign w_flush   = w_ctrl_wr & i_dat_ms[0];
    assign w_pop     = ~w_empty & i_out_ready & ~w_flush;

    always_comb begin
        w_status            = '0;
        w_status[CNT_W-1:0] = r_count;
        w_status[16]        = w_empty;
        w_status[17]        = w_full;
        w_status[18]        = r_stall;
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_prev_incr <= 1'b0;
            r_stall     <= 1'b0;
            r_dat_sm    <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
        end else begin
            r_ack       <= w_ack;
            r_err       <= w_err;
            r_prev_incr <= (w_ack | w_err) & w_incr;

            if (w_ack & ~i_we) begin
                r_dat_sm <= (w_region == 2'd1) ? w_status : '0;
            end

            if (w_hold) begin
                r_stall <= 1'b1;
            end else if (w_ctrl_wr & i_dat_ms[1]) begin
                r_stall <= 1'b0;
            end

            if (w_flush) begin
                r_rptr  <= r_wptr;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                if (w_push & ~w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (w_pop & ~w_push) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: the head is masked to 0 while the FIFO is empty.
    always_ff @(posedge i_sys_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_dat_ms;
        end
    end

    assign o_ack       = r_ack;
    assign o_err       = r_err;
    assign o_rty       = 1'b0;
    assign o_dat_sm    = r_dat_sm;
    assign o_out_valid = ~w_empty;
    assign o_out_data  = w_empty ? '0 : r_mem[r_rptr];

    assign w_unused = ^{i_bte, i_adr[31:4], i_adr[1:0]};

endmodule

// File: tb/tb_wshb_stream_sink.sv
// Scoreboard bench for wshb_stream_sink: a queue-based reference model pushes
// expected terminations; a negedge monitor pops and compares them.
module tb_wshb_stream_sink;

    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        b_cyc = 0, b_stb = 0, b_we = 0, b_out_ready = 0;
    logic [31:0] b_adr = '0, b_dat = '0;
    logic [3:0]  b_sel = '0;
    logic [2:0]  b_cti = '0;
    logic [1:0]  b_bte = '0;

    logic [31:0] d_dat_sm, d_out_data;
    logic        d_ack, d_err, d_rty, d_out_valid;

    wshb_stream_sink #(.DEPTH(DEPTH)) dut (
        .i_sys_clk   (clk),
        .i_sys_rst_n (rst_n),
        .i_cyc       (b_cyc),
        .i_stb       (b_stb),
        .i_we        (b_we),
        .i_adr       (b_adr),
        .i_dat_ms    (b_dat),
        .i_sel       (b_sel),
        .i_cti       (b_cti),
        .i_bte       (b_bte),
        .o_dat_sm    (d_dat_sm),
        .o_ack       (d_ack),
        .o_err       (d_err),
        .o_rty       (d_rty),
        .o_out_data  (d_out_data),
        .o_out_valid (d_out_valid),
        .i_out_ready (b_out_ready)
    );

    typedef struct {
        bit          is_err;
        bit          is_read;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_q[$];
    bit          m_stall = 0, m_term_prev = 0, m_prev_incr = 0;
    bit          rnd_ready = 0;
    int          n_checks = 0, n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] w;
        w = 32'(m_q.size());
        if (m_q.size() == 0) w = w | 32'h0001_0000;
        if (m_q.size() == int'(DEPTH)) w = w | 32'h0002_0000;
        if (m_stall) w = w | 32'h0004_0000;
        return w;
    endfunction

    // Reference model: one Wishbone beat per cycle, FIFO as a queue.
    bit         p_pres, p_err, p_dwr, p_hold, p_ack, p_flush, p_pop;
    logic [1:0] p_a;
    exp_t       p_e;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            sb.delete();
            m_stall     = 0;
            m_term_prev = 0;
            m_prev_incr = 0;
        end else begin
            p_a     = b_adr[3:2];
            p_pres  = b_cyc && b_stb && (!m_term_prev || m_prev_incr);
            p_err   = p_pres && (p_a == 2'd3 || (b_we && b_sel != 4'hF));
            p_dwr   = p_pres && !p_err && b_we && p_a == 2'd0;
            p_hold  = p_dwr && (m_q.size() >= int'(DEPTH));
            p_ack   = p_pres && !p_err && !p_hold;
            p_flush = p_ack && b_we && p_a == 2'd2 && b_dat[0];
            p_pop   = (m_q.size() != 0) && b_out_ready && !p_flush;
            if (p_ack || p_err) begin
                p_e.is_err  = p_err;
                p_e.is_read = !b_we;
                p_e.rdata   = (p_a == 2'd1) ? model_status() : 32'h0;
                sb.push_back(p_e);
            end
            if (p_flush) begin
                m_q.delete();
            end else begin
                if (p_pop) void'(m_q.pop_front());
                if (p_dwr && !p_hold) m_q.push_back(b_dat);
            end
            if (p_hold) m_stall = 1;
            else if (p_ack && b_we && p_a == 2'd2 && b_dat[1]) m_stall = 0;
            m_prev_incr = (p_ack || p_err) && b_cti == 3'b010;
            m_term_prev = p_ack || p_err;
        end
    end

    // Monitor: every expected termination must appear in the cycle after its beat.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (d_ack || d_err) begin
                if (sb.size() == 0) begin
                    check("term_unexpected", 32'({d_err, d_ack}), 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check("term_kind", 32'({d_err, d_ack}), mon_e.is_err ? 32'h2 : 32'h1);
                    if (!mon_e.is_err && mon_e.is_read) check("read_data", d_dat_sm, mon_e.rdata);
                end
            end else if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("term_missing", 32'({d_err, d_ack}), mon_e.is_err ? 32'h2 : 32'h1);
            end
            check("rty", 32'(d_rty), 32'h0);
            check("out_valid", 32'(d_out_valid), 32'(m_q.size() != 0));
            check("out_data", d_out_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) b_out_ready = ($urandom_range(0, 2) == 0);
    endtask

    task automatic drive(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] cti);
        b_cyc = 1; b_stb = 1; b_we = we; b_adr = adr; b_dat = dat; b_sel = sel; b_cti = cti;
        b_bte = 2'($urandom_range(0, 3));
    endtask

    task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [1:0] term,
                           output logic [31:0] rd);
        term = 2'b00;
        rd   = '0;
        drive(we, adr, dat, sel, 3'b000);
        for (int i = 0; i < 64; i++) begin
            tick();
            if (m_term_prev) begin
                term = {d_err, d_ack};
                rd   = d_dat_sm;
                break;
            end
        end
        b_stb = 0;
        tick();
        b_cyc = 0;
    endtask

    task automatic wb_burst(input int n, input logic [31:0] base, output int n_acked);
        n_acked = 0;
        for (int b = 0; b < n; b++) begin
            drive(1, 32'h0, base + 32'(b), 4'hF, (b == n - 1) ? 3'b111 : 3'b010);
            for (int i = 0; i < 64; i++) begin
                tick();
                if (m_term_prev) begin
                    if (d_ack) n_acked++;
                    break;
                end
            end
        end
        b_stb = 0;
        tick();
        b_cyc = 0;
    endtask

    logic [1:0]  term;
    logic [31:0] rd, dat;
    int          nacc, got, kind, a;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(d_ack), 32'h0);
        check("rst_err", 32'(d_err), 32'h0);
        check("rst_dat_sm", d_dat_sm, 32'h0);
        check("rst_out_valid", 32'(d_out_valid), 32'h0);
        check("rst_out_data", d_out_data, 32'h0);
        rst_n = 1;
        tick();

        // Reset in the middle of an incrementing write burst
        got = 0;
        drive(1, 32'h0, 32'hA000_0000, 4'hF, 3'b010);
        for (int i = 0; i < 20 && got < 3; i++) begin
            tick();
            if (m_term_prev) begin
                got++;
                b_dat = b_dat + 1;
            end
        end
        check("t1_ack_before_reset", 32'(d_ack), 32'h1);
        check("t1_valid_before_reset", 32'(d_out_valid), 32'h1);
        #1 rst_n = 0;
        #1;
        check("t1_ack_async", 32'(d_ack), 32'h0);
        check("t1_valid_async", 32'(d_out_valid), 32'h0);
        check("t1_data_async", d_out_data, 32'h0);
        b_cyc = 0; b_stb = 0;
        tick();
        rst_n = 1;
        tick();

        // Classic write then STATUS read
        wb_xfer(1, 32'h0, 32'hDEAD_BEEF, 4'hF, term, rd);
        check("t2_write_ack", 32'(term), 32'h1);
        wb_xfer(0, 32'h4, 32'h0, 4'hF, term, rd);
        check("t2_status", rd, 32'h0000_0001);
        check("t2_out_valid", 32'(d_out_valid), 32'h1);
        check("t2_out_data", d_out_data, 32'hDEAD_BEEF);

        // Incrementing burst of 4 into an empty FIFO
        wb_xfer(1, 32'h8, 32'h1, 4'hF, term, rd);
        wb_burst(4, 32'h3000_0000, nacc);
        check("t3_burst_acks", 32'(nacc), 32'h4);
        wb_xfer(0, 32'h4, 32'h0, 4'hF, term, rd);
        check("t3_status", rd, 32'h0000_0004);

        // Fill to DEPTH, then a held write released by a one-cycle pop
        for (int i = 0; i < 12; i++) wb_xfer(1, 32'h0, 32'h4000_0000 + 32'(i), 4'hF, term, rd);
        drive(1, 32'h0, 32'h0000_1717, 4'hF, 3'b000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_held", 32'(d_ack), 32'h0);
        end
        b_out_ready = 1;
        tick();
        b_out_ready = 0;
        check("t4_no_ack_yet", 32'(d_ack), 32'h0);
        tick();
        check("t4_ack_after_space", 32'(d_ack), 32'h1);
        b_stb = 0;
        tick();
        b_cyc = 0;
        wb_xfer(0, 32'h4, 32'h0, 4'hF, term, rd);
        check("t4_status_full_stall", rd, 32'h0006_0010);
        wb_xfer(1, 32'h8, 32'h2, 4'hF, term, rd);
        wb_xfer(0, 32'h4, 32'h0, 4'hF, term, rd);
        check("t4_status_stall_clr", rd, 32'h0002_0010);

        // Error terminations
        wb_xfer(1, 32'hC, 32'h5, 4'hF, term, rd);
        check("t5_err_adr3", 32'(term), 32'h2);
        wb_xfer(1, 32'h0, 32'h55, 4'h3, term, rd);
        check("t5_err_sel", 32'(term), 32'h2);
        wb_xfer(0, 32'hC, 32'h0, 4'hF, term, rd);
        check("t5_err_read", 32'(term), 32'h2);
        wb_xfer(0, 32'h4, 32'h0, 4'hF, term, rd);
        check("t5_count_unchanged", rd, 32'h0002_0010);

        // Flush wins over a simultaneous pop
        wb_xfer(1, 32'h8, 32'h1, 4'hF, term, rd);
        for (int i = 0; i < 5; i++) wb_xfer(1, 32'h0, 32'h6000_0000 + 32'(i), 4'hF, term, rd);
        wb_xfer(0, 32'h4, 32'h0, 4'hF, term, rd);
        check("t6_status_5", rd, 32'h0000_0005);
        drive(1, 32'h8, 32'h1, 4'hF, 3'b000);
        b_out_ready = 1;
        tick();
        b_out_ready = 0;
        check("t6_flush_ack", 32'(d_ack), 32'h1);
        check("t6_valid_after_flush", 32'(d_out_valid), 32'h0);
        b_stb = 0;
        tick();
        b_cyc = 0;
        wb_xfer(0, 32'h4, 32'h0, 4'hF, term, rd);
        check("t6_status_empty", rd, 32'h0001_0000);

        // Randomized traffic against the model
        rnd_ready = 1;
        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 9);
            if (kind < 3) begin
                wb_burst($urandom_range(1, 6), $urandom, nacc);
            end else begin
                a = $urandom_range(0, 99);
                a = (a < 50) ? 0 : (a < 75) ? 1 : (a < 90) ? 2 : 3;
                dat = $urandom;
                if (a == 2) dat[0] = ($urandom_range(0, 7) == 0);
                wb_xfer(1'($urandom_range(0, 1)),
                        ($urandom & 32'hFFFF_FFF3) | (32'(a) << 2), dat,
                        ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF, term, rd);
            end
            if ($urandom_range(0, 4) == 0) tick();
        end
        rnd_ready = 0;
        b_out_ready = 1;
        repeat (DEPTH + 4) tick();
        b_out_ready = 0;
        check("final_drained", 32'(d_out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
